tang_btn_reader: RTL and testbench

Memory-mapped input peripheral that lets software on the core read the Tang Nano push-buttons. It is the read-direction counterpart of the LED register peripheral and sits on the same simple select/ready bus. Each raw button pin is synchronized and debounced. Press and release edges are captured into sticky write-1-to-clear event flags. An optional level interrupt is raised to the core.

---
 rtl/tang_btn_pkg.sv | 15 +
 rtl/btn_debounce.sv | 78 +++++++
 rtl/tang_btn_reader.sv | 111 +++++++++++
 tb/tb_tang_btn_reader.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tang_btn_pkg.sv
// Shared constants and types for the Tang Nano push-button reader peripheral.
package tang_btn_pkg;

    localparam logic [1:0] ADDR_STATUS   = 2'd0;
    localparam logic [1:0] ADDR_EVENT    = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

    localparam int unsigned RELEASE_SHIFT = 8;

    typedef enum logic {
        STABLE,
        COUNTING
    } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: polarity normalisation, 2-flop synchronizer and counter debouncer
// emitting single-cycle press/release pulses aligned with the stable-level update.
module btn_debounce
    import tang_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned CNT_W           = 19,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    deb_state_t       r_state;

    logic             w_norm;
    logic             w_sample;
    logic             w_stable_n;
    logic [CNT_W-1:0] w_cnt_n;
    deb_state_t       w_state_n;

    assign w_norm   = ACTIVE_LOW ? ~i_pin : i_pin;
    assign w_sample = r_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_state  <= STABLE;
        end else begin
            r_sync   <= {r_sync[0], w_norm};
            r_stable <= w_stable_n;
            r_cnt    <= w_cnt_n;
            r_state  <= w_state_n;
        end
    end

    // Leaving STABLE counts the first differing edge, so cnt tracks edges seen.
    always_comb begin
        w_stable_n      = r_stable;
        w_cnt_n         = '0;
        w_state_n       = STABLE;
        o_press_pulse   = 1'b0;
        o_release_pulse = 1'b0;
        case (r_state)
            STABLE: begin
                if (w_sample != r_stable) begin
                    w_cnt_n   = CNT_W'(1);
                    w_state_n = COUNTING;
                end
            end
            COUNTING: begin
                if (w_sample == r_stable) begin
                    w_state_n = STABLE;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_stable_n      = w_sample;
                    o_press_pulse   = w_sample;
                    o_release_pulse = ~w_sample;
                end else begin
                    w_cnt_n   = r_cnt + CNT_W'(1);
                    w_state_n = COUNTING;
                end
            end
            default: w_state_n = STABLE;
        endcase
    end

    assign o_level = r_stable;

endmodule

// File: rtl/tang_btn_reader.sv
// Memory-mapped push-button reader: STATUS, W1C EVENT flags and optional IRQ.
// Define BTN_IRQ_EN to build the IRQ_MASK register and the btn_irq output.
module tang_btn_reader
    import tang_btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned CNT_W           = 19,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic               btn_sel,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        btn_data_i,
    output logic               btn_ready,
    output logic [31:0]        btn_data_o
`ifdef BTN_IRQ_EN
    ,
    output logic               btn_irq
`endif
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] w_clr_press;
    logic [NUM_BTN-1:0] w_clr_release;
    logic               w_wr;
    logic               w_unused;

    logic [NUM_BTN-1:0] r_evt_press;
    logic [NUM_BTN-1:0] r_evt_release;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_pin           (btn_i[g]),
            .o_level         (w_level[g]),
            .o_press_pulse   (w_press[g]),
            .o_release_pulse (w_release[g])
        );
    end

    assign btn_ready     = btn_sel;
    assign w_wr          = btn_sel & we;
    assign w_clr_press   = (w_wr && addr == ADDR_EVENT) ? btn_data_i[NUM_BTN-1:0] : '0;
    assign w_clr_release = (w_wr && addr == ADDR_EVENT) ? btn_data_i[RELEASE_SHIFT +: NUM_BTN] : '0;
    assign w_unused      = ^btn_data_i;

    // Set is OR-ed after the clear so a same-cycle pulse wins over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_press   <= '0;
            r_evt_release <= '0;
        end else begin
            r_evt_press   <= (r_evt_press & ~w_clr_press) | w_press;
            r_evt_release <= (r_evt_release & ~w_clr_release) | w_release;
        end
    end

`ifdef BTN_IRQ_EN
    logic [NUM_BTN-1:0] r_mask_press;
    logic [NUM_BTN-1:0] r_mask_release;
    logic               r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask_press   <= '0;
            r_mask_release <= '0;
            r_irq          <= 1'b0;
        end else begin
            if (w_wr && addr == ADDR_IRQ_MASK) begin
                r_mask_press   <= btn_data_i[NUM_BTN-1:0];
                r_mask_release <= btn_data_i[RELEASE_SHIFT +: NUM_BTN];
            end
            r_irq <= |{r_evt_press & r_mask_press, r_evt_release & r_mask_release};
        end
    end

    assign btn_irq = r_irq;
`endif

    always_comb begin
        btn_data_o = '0;
        if (btn_sel) begin
            case (addr)
                ADDR_STATUS: btn_data_o[NUM_BTN-1:0] = w_level;
                ADDR_EVENT: begin
                    btn_data_o[NUM_BTN-1:0]              = r_evt_press;
                    btn_data_o[RELEASE_SHIFT +: NUM_BTN] = r_evt_release;
                end
`ifdef BTN_IRQ_EN
                ADDR_IRQ_MASK: begin
                    btn_data_o[NUM_BTN-1:0]              = r_mask_press;
                    btn_data_o[RELEASE_SHIFT +: NUM_BTN] = r_mask_release;
                end
`endif
                default: btn_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tang_btn_reader.sv
// Directed bench for tang_btn_reader: vector table plus hand-written multi-cycle sequences.
module tb_tang_btn_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  btn_i = 2'b11;
    logic        btn_sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] btn_data_i = '0;
    logic        btn_ready;
    logic [31:0] btn_data_o;
`ifdef BTN_IRQ_EN
    logic        btn_irq;
    localparam logic [31:0] MASK_EXP = 32'h0000_0002;
`else
    localparam logic [31:0] MASK_EXP = 32'h0000_0000;
`endif

    int n_chk = 0;
    int n_fail = 0;

    tang_btn_reader #(
        .NUM_BTN         (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_i      (btn_i),
        .btn_sel    (btn_sel),
        .we         (we),
        .addr       (addr),
        .btn_data_i (btn_data_i),
        .btn_ready  (btn_ready),
        .btn_data_o (btn_data_o)
`ifdef BTN_IRQ_EN
        ,
        .btn_irq    (btn_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) check("ready_eq_sel", {31'd0, btn_ready}, {31'd0, btn_sel});

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        btn_sel = 1'b1; we = 1'b1; addr = a; btn_data_i = d;
        @(posedge clk); #1;
        btn_sel = 1'b0; we = 1'b0; btn_data_i = '0;
    endtask

    task automatic bus_read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        btn_sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, btn_data_o, exp);
        btn_sel = 1'b0;
        #1;
        check({name, "_unsel"}, btn_data_o, 32'h0);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  btn;
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          n_edges;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"rst_status", 2'b11, 1'b0, 2'd0, 32'h0,         0, 2'd0, 32'h000});
        vecs.push_back('{"rst_event",  2'b11, 1'b0, 2'd0, 32'h0,         0, 2'd1, 32'h000});
        vecs.push_back('{"press_e5",   2'b10, 1'b0, 2'd0, 32'h0,         5, 2'd0, 32'h000});
        vecs.push_back('{"press_e6",   2'b10, 1'b0, 2'd0, 32'h0,         1, 2'd0, 32'h001});
        vecs.push_back('{"press_evt",  2'b10, 1'b0, 2'd0, 32'h0,         0, 2'd1, 32'h001});
        vecs.push_back('{"rel_e5",     2'b11, 1'b0, 2'd0, 32'h0,         5, 2'd0, 32'h001});
        vecs.push_back('{"rel_e6",     2'b11, 1'b0, 2'd0, 32'h0,         1, 2'd0, 32'h000});
        vecs.push_back('{"rel_evt",    2'b11, 1'b0, 2'd0, 32'h0,         0, 2'd1, 32'h101});
        vecs.push_back('{"w1c_bit0",   2'b11, 1'b1, 2'd1, 32'h001,       0, 2'd1, 32'h100});
        vecs.push_back('{"w1c_zero",   2'b11, 1'b1, 2'd1, 32'h000,       0, 2'd1, 32'h100});
        vecs.push_back('{"status_ro",  2'b11, 1'b1, 2'd0, 32'hFFFF_FFFF, 0, 2'd0, 32'h000});
        vecs.push_back('{"rsvd_rd",    2'b11, 1'b1, 2'd3, 32'hFFFF_FFFF, 0, 2'd3, 32'h000});
        vecs.push_back('{"rsvd_evt",   2'b11, 1'b0, 2'd0, 32'h0,         0, 2'd1, 32'h100});
        vecs.push_back('{"glitch_lo",  2'b01, 1'b0, 2'd0, 32'h0,         3, 2'd0, 32'h000});
        vecs.push_back('{"glitch_hi",  2'b11, 1'b0, 2'd0, 32'h0,         6, 2'd0, 32'h000});
        vecs.push_back('{"glitch_evt", 2'b11, 1'b0, 2'd0, 32'h0,         0, 2'd1, 32'h100});
        vecs.push_back('{"irq_mask",   2'b11, 1'b1, 2'd2, 32'hFFFF_0002, 0, 2'd2, MASK_EXP});

        // Reset with buttons released
        reset_n = 1'b0;
        btn_i = 2'b11;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
`ifdef BTN_IRQ_EN
        check("rst_irq", {31'd0, btn_irq}, 32'h0);
`endif
        edges(3);

        foreach (vecs[i]) begin
            btn_i = vecs[i].btn;
            if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            edges(vecs[i].n_edges);
            bus_read_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Press btn1 and clear its EVENT bit on the very edge the press pulse fires
        btn_i = 2'b01;
        edges(5);
        bus_write(2'd1, 32'h0000_0002);
        bus_read_check("coll_evt", 2'd1, 32'h102);
        bus_read_check("coll_status", 2'd0, 32'h002);
`ifdef BTN_IRQ_EN
        check("irq_not_yet", {31'd0, btn_irq}, 32'h0);
        edges(1);
        check("irq_set", {31'd0, btn_irq}, 32'h1);
        bus_write(2'd1, 32'h0000_0102);
        check("irq_hold", {31'd0, btn_irq}, 32'h1);
        bus_read_check("clr_evt", 2'd1, 32'h000);
        edges(1);
        check("irq_drop", {31'd0, btn_irq}, 32'h0);
`else
        bus_write(2'd1, 32'h0000_0102);
        bus_read_check("clr_evt", 2'd1, 32'h000);
`endif

        // Reset mid-debounce with both buttons held: partial count discarded
        btn_i = 2'b00;
        edges(4);
        reset_n = 1'b0;
        #1;
        bus_read_check("rst_mid_evt", 2'd1, 32'h000);
        bus_read_check("rst_mid_status", 2'd0, 32'h000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        edges(5);
        bus_read_check("held_e5", 2'd0, 32'h000);
        edges(1);
        bus_read_check("held_status", 2'd0, 32'h003);
        bus_read_check("held_evt", 2'd1, 32'h003);
`ifdef BTN_IRQ_EN
        edges(1);
        check("held_irq_masked", {31'd0, btn_irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
